// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one SDRAM controller between the display fetch, the command engine,
// the CPU port and a self-timed refresh scheduler. It spaces commands OP_SPACING clocks apart
// and routes each read's data back to the requester that issued it.
// Width code on mem_word_wr_size: 2'b00 = 8-bit, 2'b01 = 16-bit, 2'b10 = 32-bit.
module vram_arbiter #(
    parameter int unsigned REFRESH_INTERVAL = 406,
    parameter int unsigned OP_SPACING       = 6,
    parameter int unsigned RD_LATENCY       = 5
) (
    input  logic        i_clk,
    input  logic        i_reset,
    // display fetch
    input  logic        i_disp_req,
    input  logic [22:0] i_disp_addr,
    output logic        o_disp_grant,
    output logic        o_disp_rvalid,
    // command engine
    input  logic        i_cmd_req,
    input  logic        i_cmd_we,
    input  logic [22:0] i_cmd_addr,
    input  logic [1:0]  i_cmd_size,
    input  logic [7:0]  i_cmd_din8,
    input  logic [15:0] i_cmd_din16,
    input  logic [31:0] i_cmd_din32,
    output logic        o_cmd_grant,
    output logic        o_cmd_rvalid,
    // CPU port
    input  logic        i_cpu_req,
    input  logic        i_cpu_we,
    input  logic [22:0] i_cpu_addr,
    input  logic [7:0]  i_cpu_din8,
    output logic        o_cpu_grant,
    output logic        o_cpu_rvalid,
    // shared read data
    output logic [15:0] o_rdata,
    // memory controller
    output logic        o_mem_read,
    output logic        o_mem_write,
    output logic        o_mem_refresh,
    output logic [22:0] o_mem_addr,
    output logic [1:0]  o_mem_word_wr_size,
    output logic [7:0]  o_mem_din8,
    output logic [15:0] o_mem_din16,
    output logic [31:0] o_mem_din32,
    input  logic [15:0] i_mem_dout16,
    input  logic        i_mem_enabled,
    output logic        o_refresh_overrun
);

    localparam logic [1:0]    SIZE_8     = 2'b00;
    localparam int unsigned   TW         = $clog2(REFRESH_INTERVAL);
    localparam int unsigned   CW         = (OP_SPACING > 2) ? $clog2(OP_SPACING) : 1;
    localparam int unsigned   LW         = $clog2(RD_LATENCY + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(REFRESH_INTERVAL - 1);
    localparam logic [CW-1:0] HOLD_LAST  = CW'(OP_SPACING - 1);
    // Issue clock plus OP_SPACING-1 busy clocks gives the full spacing.
    localparam logic [CW-1:0] BUSY_LOAD  = CW'(OP_SPACING - 2);
    localparam logic [LW-1:0] RD_LOAD    = LW'(RD_LATENCY);

    typedef enum logic [1:0] {StInit, StIdle, StBusy} state_e;
    typedef enum logic [1:0] {OwnDisp, OwnCmd, OwnCpu} owner_e;

    state_e        r_state, w_state_next;
    logic [CW-1:0] r_cnt, w_cnt_next;
    logic [TW-1:0] r_timer;
    logic [2:0]    r_owed, w_owed_next;
    logic          r_overrun, w_overrun_next;
    logic          r_rr_last_cpu;

    logic          r_rd_pend;
    logic [LW-1:0] r_rd_cnt;
    owner_e        r_rd_owner;
    logic [15:0]   r_rdata;

    logic          r_disp_grant, r_cmd_grant, r_cpu_grant;
    logic          r_disp_rvalid, r_cmd_rvalid, r_cpu_rvalid;
    logic          r_mem_read, r_mem_write, r_mem_refresh;
    logic [22:0]   r_mem_addr;
    logic [1:0]    r_mem_size;
    logic [7:0]    r_mem_din8;
    logic [15:0]   r_mem_din16;
    logic [31:0]   r_mem_din32;

    logic w_tick, w_cmd_wins;
    logic w_issue_ref, w_issue_disp, w_issue_cmd, w_issue_cpu, w_issue_read;

    assign w_tick       = (r_timer == TIMER_LAST);
    // cmd wins alone, or against the CPU when the CPU had the last turn.
    assign w_cmd_wins   = i_cmd_req && (!i_cpu_req || r_rr_last_cpu);
    assign w_issue_read = w_issue_disp | (w_issue_cmd & ~i_cmd_we) | (w_issue_cpu & ~i_cpu_we);

    // Next-state and issue decision; commands leave only from StIdle with the controller enabled.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_issue_ref  = 1'b0;
        w_issue_disp = 1'b0;
        w_issue_cmd  = 1'b0;
        w_issue_cpu  = 1'b0;
        unique case (r_state)
            StInit: begin
                if (!i_mem_enabled) begin
                    w_cnt_next = '0;
                end else if (r_cnt == HOLD_LAST) begin
                    w_state_next = StIdle;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            StIdle: begin
                if (!i_mem_enabled) begin
                    w_state_next = StInit;
                    w_cnt_next   = '0;
                end else begin
                    if (r_owed >= 3'd2)      w_issue_ref  = 1'b1;
                    else if (i_disp_req)     w_issue_disp = 1'b1;
                    else if (r_owed == 3'd1) w_issue_ref  = 1'b1;
                    else if (w_cmd_wins)     w_issue_cmd  = 1'b1;
                    else if (i_cpu_req)      w_issue_cpu  = 1'b1;
                    if (w_issue_ref | w_issue_disp | w_issue_cmd | w_issue_cpu) begin
                        w_state_next = StBusy;
                        w_cnt_next   = BUSY_LOAD;
                    end
                end
            end
            StBusy: begin
                if (r_cnt == '0) w_state_next = StIdle;
                else             w_cnt_next   = r_cnt - 1'b1;
            end
            default: begin
                w_state_next = StInit;
                w_cnt_next   = '0;
            end
        endcase
    end

    // Refresh debt: a tick and a refresh issue in the same clock cancel out.
    always_comb begin
        w_owed_next    = r_owed;
        w_overrun_next = r_overrun;
        if (w_tick && !w_issue_ref) begin
            if (r_owed == 3'd7) w_overrun_next = 1'b1;
            else                w_owed_next    = r_owed + 3'd1;
        end else if (!w_tick && w_issue_ref) begin
            w_owed_next = r_owed - 3'd1;
        end
    end

    // State register for the sequencing FSM.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= StInit;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Free-running refresh timer (runs in every state) and refresh debt bookkeeping.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_timer   <= '0;
            r_owed    <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_timer   <= w_tick ? '0 : r_timer + 1'b1;
            r_owed    <= w_owed_next;
            r_overrun <= w_overrun_next;
        end
    end

    // Registered command pulses, grants and the winner's address/size/data.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_disp_grant  <= 1'b0;
            r_cmd_grant   <= 1'b0;
            r_cpu_grant   <= 1'b0;
            r_mem_read    <= 1'b0;
            r_mem_write   <= 1'b0;
            r_mem_refresh <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_size    <= '0;
            r_mem_din8    <= '0;
            r_mem_din16   <= '0;
            r_mem_din32   <= '0;
            r_rr_last_cpu <= 1'b1;
        end else begin
            r_disp_grant  <= w_issue_disp;
            r_cmd_grant   <= w_issue_cmd;
            r_cpu_grant   <= w_issue_cpu;
            r_mem_read    <= w_issue_read;
            r_mem_write   <= (w_issue_cmd & i_cmd_we) | (w_issue_cpu & i_cpu_we);
            r_mem_refresh <= w_issue_ref;
            if (w_issue_disp) begin
                r_mem_addr <= i_disp_addr;
            end
            if (w_issue_cmd) begin
                r_mem_addr    <= i_cmd_addr;
                r_mem_size    <= i_cmd_size;
                r_mem_din8    <= i_cmd_din8;
                r_mem_din16   <= i_cmd_din16;
                r_mem_din32   <= i_cmd_din32;
                r_rr_last_cpu <= 1'b0;
            end
            if (w_issue_cpu) begin
                r_mem_addr    <= i_cpu_addr;
                r_mem_size    <= SIZE_8;
                r_mem_din8    <= i_cpu_din8;
                r_rr_last_cpu <= 1'b1;
            end
        end
    end

    // Read return: capture controller data RD_LATENCY+1 clocks after issue, flag the owner.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rd_pend     <= 1'b0;
            r_rd_cnt      <= '0;
            r_rd_owner    <= OwnDisp;
            r_rdata       <= '0;
            r_disp_rvalid <= 1'b0;
            r_cmd_rvalid  <= 1'b0;
            r_cpu_rvalid  <= 1'b0;
        end else begin
            r_disp_rvalid <= 1'b0;
            r_cmd_rvalid  <= 1'b0;
            r_cpu_rvalid  <= 1'b0;
            if (r_rd_pend) begin
                if (r_rd_cnt == '0) begin
                    r_rdata       <= i_mem_dout16;
                    r_rd_pend     <= 1'b0;
                    r_disp_rvalid <= (r_rd_owner == OwnDisp);
                    r_cmd_rvalid  <= (r_rd_owner == OwnCmd);
                    r_cpu_rvalid  <= (r_rd_owner == OwnCpu);
                end else begin
                    r_rd_cnt <= r_rd_cnt - 1'b1;
                end
            end
            // A new read may issue on the same clock the previous one is captured.
            if (w_issue_read) begin
                r_rd_pend <= 1'b1;
                r_rd_cnt  <= RD_LOAD;
                if (w_issue_disp)     r_rd_owner <= OwnDisp;
                else if (w_issue_cmd) r_rd_owner <= OwnCmd;
                else                  r_rd_owner <= OwnCpu;
            end
        end
    end

    assign o_disp_grant       = r_disp_grant;
    assign o_cmd_grant        = r_cmd_grant;
    assign o_cpu_grant        = r_cpu_grant;
    assign o_disp_rvalid      = r_disp_rvalid;
    assign o_cmd_rvalid       = r_cmd_rvalid;
    assign o_cpu_rvalid       = r_cpu_rvalid;
    assign o_rdata            = r_rdata;
    assign o_mem_read         = r_mem_read;
    assign o_mem_write        = r_mem_write;
    assign o_mem_refresh      = r_mem_refresh;
    assign o_mem_addr         = r_mem_addr;
    assign o_mem_word_wr_size = r_mem_size;
    assign o_mem_din8         = r_mem_din8;
    assign o_mem_din16        = r_mem_din16;
    assign o_mem_din32        = r_mem_din32;
    assign o_refresh_overrun  = r_overrun;

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: randomized and directed checks of vram_arbiter against a time-based
// reference model (issue allowed once the edge count reaches the next permitted slot).
module tb_vram_arbiter;

    localparam int RI  = 406;
    localparam int OPS = 6;
    localparam int RDL = 5;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        disp_req, cmd_req, cmd_we, cpu_req, cpu_we, mem_enabled;
    logic [22:0] disp_addr, cmd_addr, cpu_addr;
    logic [1:0]  cmd_size;
    logic [7:0]  cmd_din8, cpu_din8;
    logic [15:0] cmd_din16, mem_dout16;
    logic [31:0] cmd_din32;

    logic        o_disp_grant, o_disp_rvalid, o_cmd_grant, o_cmd_rvalid;
    logic        o_cpu_grant, o_cpu_rvalid, o_mem_read, o_mem_write, o_mem_refresh;
    logic        o_refresh_overrun;
    logic [15:0] o_rdata, o_mem_din16;
    logic [22:0] o_mem_addr;
    logic [1:0]  o_mem_word_wr_size;
    logic [7:0]  o_mem_din8;
    logic [31:0] o_mem_din32;

    vram_arbiter #(
        .REFRESH_INTERVAL(RI),
        .OP_SPACING      (OPS),
        .RD_LATENCY      (RDL)
    ) dut (
        .i_clk             (clk),
        .i_reset           (reset),
        .i_disp_req        (disp_req),
        .i_disp_addr       (disp_addr),
        .o_disp_grant      (o_disp_grant),
        .o_disp_rvalid     (o_disp_rvalid),
        .i_cmd_req         (cmd_req),
        .i_cmd_we          (cmd_we),
        .i_cmd_addr        (cmd_addr),
        .i_cmd_size        (cmd_size),
        .i_cmd_din8        (cmd_din8),
        .i_cmd_din16       (cmd_din16),
        .i_cmd_din32       (cmd_din32),
        .o_cmd_grant       (o_cmd_grant),
        .o_cmd_rvalid      (o_cmd_rvalid),
        .i_cpu_req         (cpu_req),
        .i_cpu_we          (cpu_we),
        .i_cpu_addr        (cpu_addr),
        .i_cpu_din8        (cpu_din8),
        .o_cpu_grant       (o_cpu_grant),
        .o_cpu_rvalid      (o_cpu_rvalid),
        .o_rdata           (o_rdata),
        .o_mem_read        (o_mem_read),
        .o_mem_write       (o_mem_write),
        .o_mem_refresh     (o_mem_refresh),
        .o_mem_addr        (o_mem_addr),
        .o_mem_word_wr_size(o_mem_word_wr_size),
        .o_mem_din8        (o_mem_din8),
        .o_mem_din16       (o_mem_din16),
        .o_mem_din32       (o_mem_din32),
        .i_mem_dout16      (mem_dout16),
        .i_mem_enabled     (mem_enabled),
        .o_refresh_overrun (o_refresh_overrun)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state. Owner index: 2 = display, 1 = command, 0 = CPU.
    int          m_edge = 0, m_t = 0, m_hold = 0, m_next = 0, m_owed = 0;
    int          m_rd_due = -1, m_rd_owner = 0;
    bit          m_run = 0, m_ovr = 0, m_rr_cpu = 1, m_rd_issued = 0;
    logic [2:0]  e_grant = '0, e_rvalid = '0;
    logic        e_rd = 0, e_wr = 0, e_ref = 0;
    logic [22:0] e_addr = '0;
    logic [1:0]  e_size = '0;
    logic [7:0]  e_din8 = '0;
    logic [15:0] e_din16 = '0, e_rdata = '0;
    logic [31:0] e_din32 = '0;
    logic [106:0] exp_vec, act_vec;

    // Memory controller model: read data valid only in the clock RDL after the issue clock.
    int          c_cd = 0;
    logic [15:0] c_val = '0;
    bit          c_fix = 0;
    logic [15:0] c_fix_val = '0;

    task automatic model_edge();
        int win;
        bit is_ref, tick;
        m_edge++;
        e_grant = '0; e_rvalid = '0; e_rd = 0; e_wr = 0; e_ref = 0; m_rd_issued = 0;
        if (reset) begin
            m_t = 0; m_run = 0; m_hold = 0; m_next = 0; m_owed = 0; m_ovr = 0;
            m_rr_cpu = 1; m_rd_due = -1;
            e_addr = '0; e_size = '0; e_din8 = '0; e_din16 = '0; e_din32 = '0; e_rdata = '0;
            return;
        end
        m_t++;
        tick = ((m_t % RI) == 0);
        if (m_rd_due == m_edge) begin
            e_rvalid[m_rd_owner] = 1'b1;
            e_rdata  = c_val;
            m_rd_due = -1;
        end
        win = -1; is_ref = 0;
        if (!m_run) begin
            if (mem_enabled) begin
                m_hold++;
                if (m_hold == OPS) begin m_run = 1; m_next = m_edge + 1; end
            end else m_hold = 0;
        end else if (m_edge >= m_next) begin
            if (!mem_enabled) begin
                m_run = 0; m_hold = 0;
            end else begin
                if (m_owed >= 2)              is_ref = 1;
                else if (disp_req)            win = 2;
                else if (m_owed == 1)         is_ref = 1;
                else if (cmd_req && cpu_req)  win = m_rr_cpu ? 1 : 0;
                else if (cmd_req)             win = 1;
                else if (cpu_req)             win = 0;
                if (is_ref || win >= 0) m_next = m_edge + OPS;
            end
        end
        if (tick && !is_ref) begin
            if (m_owed == 7) m_ovr = 1; else m_owed++;
        end else if (!tick && is_ref) m_owed--;
        e_ref = is_ref;
        if (win == 2) begin
            e_grant[2] = 1; e_rd = 1; e_addr = disp_addr;
        end else if (win == 1) begin
            e_grant[1] = 1; e_addr = cmd_addr; e_size = cmd_size;
            e_din8 = cmd_din8; e_din16 = cmd_din16; e_din32 = cmd_din32;
            if (cmd_we) e_wr = 1; else e_rd = 1;
            m_rr_cpu = 0;
        end else if (win == 0) begin
            e_grant[0] = 1; e_addr = cpu_addr; e_size = 2'b00; e_din8 = cpu_din8;
            if (cpu_we) e_wr = 1; else e_rd = 1;
            m_rr_cpu = 1;
        end
        if (e_rd) begin
            m_rd_due = m_edge + RDL + 1; m_rd_owner = win; m_rd_issued = 1;
        end
    endtask

    // One clock: DUT and model advance on the posedge, outputs sampled on the negedge.
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        exp_vec = {e_grant, e_rvalid, e_rd, e_wr, e_ref, m_ovr, e_addr, e_size,
                   e_din8, e_din16, e_din32, e_rdata};
        act_vec = {o_disp_grant, o_cmd_grant, o_cpu_grant, o_disp_rvalid, o_cmd_rvalid,
                   o_cpu_rvalid, o_mem_read, o_mem_write, o_mem_refresh, o_refresh_overrun,
                   o_mem_addr, o_mem_word_wr_size, o_mem_din8, o_mem_din16, o_mem_din32,
                   o_rdata};
        if (c_cd > 0) begin
            c_cd--;
            mem_dout16 = (c_cd == 0) ? c_val : ~c_val;
        end else mem_dout16 = ~c_val;
        if (m_rd_issued) begin
            c_cd  = RDL;
            c_val = c_fix ? c_fix_val : 16'($urandom);
        end
    endtask

    task automatic idle_inputs();
        disp_req = 0; cmd_req = 0; cpu_req = 0; cmd_we = 0; cpu_we = 0;
    endtask

    task automatic test_reset();
        int first;
        reset = 1; mem_enabled = 1;
        disp_req = 1; cmd_req = 1; cpu_req = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (act_vec !== exp_vec) begin
                n_fail++; $display("FAIL reset_state act=%h exp=%h", act_vec, exp_vec);
            end
        end
        reset = 0; mem_enabled = 0; idle_inputs();
        disp_req = 1; disp_addr = 23'($urandom);
        first = -1;
        for (int c = 0; c < 20; c++) begin
            if (c == 3) mem_enabled = 1;
            step();
            n_checks++;
            if (act_vec !== exp_vec) begin
                n_fail++; $display("FAIL startup c=%0d act=%h exp=%h", c, act_vec, exp_vec);
            end
            if (first < 0 && (o_mem_read || o_mem_write || o_mem_refresh)) first = c;
            if (e_grant[2]) disp_req = 0;
        end
        n_checks++;
        if (first < 3 + OPS) begin
            n_fail++; $display("FAIL first_issue act=%0d required>=%0d", first, 3 + OPS);
        end
    endtask

    task automatic test_disp_read();
        int g, rv;
        idle_inputs();
        for (int i = 0; i < 12; i++) begin
            step();
            n_checks++;
            if (act_vec !== exp_vec) begin
                n_fail++; $display("FAIL disp_quiet act=%h exp=%h", act_vec, exp_vec);
            end
        end
        c_fix = 1; c_fix_val = 16'hBEEF;
        disp_addr = 23'h000100; disp_req = 1;
        g = -1; rv = -1;
        for (int c = 0; c < 40; c++) begin
            step();
            n_checks++;
            if (act_vec !== exp_vec) begin
                n_fail++; $display("FAIL disp_read c=%0d act=%h exp=%h", c, act_vec, exp_vec);
            end
            if (g < 0 && o_disp_grant) begin
                g = c; disp_req = 0;
                n_checks++;
                if (!o_mem_read || o_mem_addr !== 23'h000100) begin
                    n_fail++;
                    $display("FAIL disp_issue rd=%b addr=%h required rd=1 addr=000100",
                             o_mem_read, o_mem_addr);
                end
            end
            if (rv < 0 && o_disp_rvalid) begin
                rv = c;
                n_checks++;
                if (o_rdata !== 16'hBEEF) begin
                    n_fail++; $display("FAIL disp_rdata act=%h required=beef", o_rdata);
                end
            end
        end
        n_checks++;
        if (g < 0 || rv != g + RDL + 1) begin
            n_fail++; $display("FAIL disp_rvalid_time grant=%0d rvalid=%0d required=grant+%0d",
                               g, rv, RDL + 1);
        end
        c_fix = 0;
    endtask

    task automatic test_round_robin();
        int prev, prev_c, n_g, owner;
        reset = 1; idle_inputs(); mem_enabled = 1;
        step();
        reset = 0;
        cmd_req = 1; cmd_we = 1'($urandom); cmd_addr = 23'($urandom); cmd_size = 2'($urandom_range(0, 2));
        cmd_din8 = 8'($urandom); cmd_din16 = 16'($urandom); cmd_din32 = $urandom;
        cpu_req = 1; cpu_we = 1'($urandom); cpu_addr = 23'($urandom); cpu_din8 = 8'($urandom);
        prev = -1; prev_c = -1; n_g = 0;
        for (int c = 0; c < 80; c++) begin
            step();
            n_checks++;
            if (act_vec !== exp_vec) begin
                n_fail++; $display("FAIL rr c=%0d act=%h exp=%h", c, act_vec, exp_vec);
            end
            if (o_cmd_grant || o_cpu_grant) begin
                owner = o_cmd_grant ? 1 : 0;
                n_checks++;
                if (n_g == 0 && owner != 1) begin
                    n_fail++; $display("FAIL rr_first act=%0d required=1(cmd)", owner);
                end else if (n_g > 0 && (owner == prev || c - prev_c != OPS)) begin
                    n_fail++; $display("FAIL rr_alternate owner=%0d prev=%0d gap=%0d required gap=%0d",
                                       owner, prev, c - prev_c, OPS);
                end
                prev = owner; prev_c = c; n_g++;
            end
            if (e_grant[1]) begin
                cmd_we = 1'($urandom); cmd_addr = 23'($urandom); cmd_din32 = $urandom;
            end
            if (e_grant[0]) begin
                cpu_we = 1'($urandom); cpu_addr = 23'($urandom); cpu_din8 = 8'($urandom);
            end
        end
        n_checks++;
        if (n_g < 8) begin
            n_fail++; $display("FAIL rr_grant_count act=%0d required>=8", n_g);
        end
        idle_inputs();
    endtask

    task automatic test_refresh_starve();
        int nref;
        reset = 1; idle_inputs(); mem_enabled = 1;
        step();
        reset = 0; disp_req = 1; disp_addr = 23'($urandom);
        nref = 0;
        for (int c = 0; c < 3 * RI + 20; c++) begin
            step();
            n_checks++;
            if (act_vec !== exp_vec) begin
                n_fail++; $display("FAIL starve c=%0d act=%h exp=%h", c, act_vec, exp_vec);
            end
            if (o_mem_refresh) nref++;
            if (e_grant[2]) disp_addr = 23'($urandom);
        end
        // Ticks at 1, 2 and 3 intervals; owed==1 loses to display, so owed==2 triggers twice.
        n_checks++;
        if (nref != 2 || o_refresh_overrun !== 1'b0) begin
            n_fail++; $display("FAIL starve_refresh nref=%0d ovr=%b required nref=2 ovr=0",
                               nref, o_refresh_overrun);
        end
        idle_inputs();
    endtask

    task automatic test_overrun();
        int nref;
        reset = 1; idle_inputs(); mem_enabled = 0;
        step();
        reset = 0;
        for (int c = 0; c < 8 * RI + 10; c++) begin
            step();
            n_checks++;
            if (act_vec !== exp_vec) begin
                n_fail++; $display("FAIL overrun_wait c=%0d act=%h exp=%h", c, act_vec, exp_vec);
            end
        end
        n_checks++;
        if (o_refresh_overrun !== 1'b1) begin
            n_fail++; $display("FAIL overrun_set act=%b required=1", o_refresh_overrun);
        end
        mem_enabled = 1; nref = 0;
        for (int c = 0; c < 60; c++) begin
            step();
            n_checks++;
            if (act_vec !== exp_vec) begin
                n_fail++; $display("FAIL overrun_drain c=%0d act=%h exp=%h", c, act_vec, exp_vec);
            end
            if (o_mem_refresh) nref++;
        end
        n_checks++;
        if (nref != 7) begin
            n_fail++; $display("FAIL owed_saturated refreshes=%0d required=7", nref);
        end
        reset = 1;
        step();
        reset = 0;
        step();
        n_checks++;
        if (o_refresh_overrun !== 1'b0) begin
            n_fail++; $display("FAIL overrun_clear act=%b required=0", o_refresh_overrun);
        end
    endtask

    task automatic test_cpu_write();
        int g;
        idle_inputs(); mem_enabled = 1;
        cpu_req = 1; cpu_we = 1; cpu_addr = 23'h000003; cpu_din8 = 8'h5A;
        g = -1;
        for (int c = 0; c < 40; c++) begin
            step();
            n_checks++;
            if (act_vec !== exp_vec) begin
                n_fail++; $display("FAIL cpu_write c=%0d act=%h exp=%h", c, act_vec, exp_vec);
            end
            if (g < 0 && o_cpu_grant) begin
                g = c; cpu_req = 0;
                n_checks++;
                if (!o_mem_write || o_mem_read || o_mem_word_wr_size !== 2'b00 ||
                    o_mem_din8 !== 8'h5A || o_mem_addr !== 23'h000003) begin
                    n_fail++;
                    $display("FAIL cpu_write_issue wr=%b rd=%b size=%b din8=%h addr=%h required 1 0 00 5a 000003",
                             o_mem_write, o_mem_read, o_mem_word_wr_size, o_mem_din8, o_mem_addr);
                end
            end
            n_checks++;
            if ({o_disp_rvalid, o_cmd_rvalid, o_cpu_rvalid} !== 3'b000) begin
                n_fail++; $display("FAIL cpu_write_rvalid act=%b required=000",
                                   {o_disp_rvalid, o_cmd_rvalid, o_cpu_rvalid});
            end
        end
        n_checks++;
        if (g < 0) begin
            n_fail++; $display("FAIL cpu_write_grant act=none required=grant within 40 clks");
        end
        idle_inputs();
    endtask

    task automatic test_random();
        reset = 1; idle_inputs(); mem_enabled = 1;
        step();
        reset = 0;
        for (int c = 0; c < 3000; c++) begin
            step();
            n_checks++;
            if (act_vec !== exp_vec) begin
                n_fail++; $display("FAIL random c=%0d act=%h exp=%h", c, act_vec, exp_vec);
            end
            if (e_grant[2] || (disp_req && $urandom_range(0, 99) == 0)) disp_req = 0;
            else if (!disp_req && $urandom_range(0, 5) == 0) begin
                disp_req = 1; disp_addr = 23'($urandom);
            end
            if (e_grant[1] || (cmd_req && $urandom_range(0, 99) == 0)) cmd_req = 0;
            else if (!cmd_req && $urandom_range(0, 3) == 0) begin
                cmd_req = 1; cmd_we = 1'($urandom); cmd_addr = 23'($urandom);
                cmd_size = 2'($urandom_range(0, 2)); cmd_din8 = 8'($urandom);
                cmd_din16 = 16'($urandom); cmd_din32 = $urandom;
            end
            if (e_grant[0] || (cpu_req && $urandom_range(0, 99) == 0)) cpu_req = 0;
            else if (!cpu_req && $urandom_range(0, 3) == 0) begin
                cpu_req = 1; cpu_we = 1'($urandom); cpu_addr = 23'($urandom);
                cpu_din8 = 8'($urandom);
            end
            if (mem_enabled && $urandom_range(0, 299) == 0) mem_enabled = 0;
            else if (!mem_enabled && $urandom_range(0, 29) == 0) mem_enabled = 1;
            reset = ($urandom_range(0, 999) == 0);
        end
        reset = 0; idle_inputs();
    endtask

    initial begin
        reset = 1; mem_enabled = 0; mem_dout16 = '0;
        disp_req = 0; disp_addr = '0;
        cmd_req = 0; cmd_we = 0; cmd_addr = '0; cmd_size = '0;
        cmd_din8 = '0; cmd_din16 = '0; cmd_din32 = '0;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_din8 = '0;
        test_reset();
        test_disp_read();
        test_round_robin();
        test_refresh_starve();
        test_overrun();
        test_cpu_write();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
